ddr_cmd_driver: RTL and testbench
=================================

Name: ddr_cmd_driver

Overview:
- Controller-side DDR4 command and data initiator that drives the CA bus and DQ lanes toward the DIMM model.
- Takes one transaction (read or write, bank group, bank, row, column, burst mode) and sequences ACT → tRCD → WR/RD → latency → burst → recovery → PRE → tRP.
- Serialises write data as rise/fall byte pairs with DQS enable.
- Captures read data after CL and returns a 64-bit word.

Parameters:
T_RCD, 4, cycles from ACT to WR/RD
CWL, 9, write latency, WR command to first write beat
CL, 11, read latency, RD command to first read beat
T_WR, 12, cycles from last write beat to PRE
T_RTP, 6, cycles from last read beat to PRE
T_RP, 4, cycles from PRE to req_ready

Ports:
CK_t  in  1  clock, all logic on posedge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  transaction request
req_ready  out  1  block idle, accepts request
req_rw  in  1  1 = read, 0 = write
req_bg  in  2  bank group
req_ba  in  2  bank
req_row  in  14  row address
req_col  in  10  column address
req_bl4  in  1  1 = BC4 (4 beats), 0 = BL8
req_wdata  in  64  write data; beat k = bits [8k+7:8k]
cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14  out  1 each  command pins
bg_addr  out  2  bank group pins
ba_addr  out  2  bank pins
A13, A12_BC_n, A11, A10_AP  out  1 each  address pins
A9_A0  out  10  address pins
dq_rise  out  8  beat driven on CK rising half
dq_fall  out  8  beat driven on CK falling half
dqs_oe  out  1  DQS/DQ drive enable; DQS toggles with CK while high
dq_in_rise  in  8  read beat, rising half
dq_in_fall  in  8  read beat, falling half
rd_data  out  64  assembled read word
rd_valid  out  1  one-cycle pulse, rd_data valid

Behaviour:
- Command encoding {cs_n,act_n,RAS,CAS,WE}:
  - NOP 11111.
  - ACT 00111; row[13:0] on A13..A0.
  - WR 01100, RD 01101; col on A9_A0; A12_BC_n = ~req_bl4; A10_AP = 0.
  - PRE 01010; A10_AP = 0.
- Non-command cycles drive NOP. Address pins are 0 whenever NOP is driven.
- Reset values: NOP on all command pins, all address/bg/ba pins 0, dq_rise/dq_fall 0, dqs_oe 0, rd_data 0, rd_valid 0, req_ready 1, state IDLE.
- Handshake: transfer on req_valid & req_ready at posedge. All request fields are registered at transfer. req_ready is high only in IDLE.
- States:
  - IDLE → ACT on transfer.
  - ACT: drive ACT for 1 cycle → TRCD.
  - TRCD: wait T_RCD-1 cycles → CAS.
  - CAS: drive WR/RD for 1 cycle → LAT.
  - LAT: wait CWL-1 cycles (write) or CL-1 cycles (read) → BURST.
  - BURST: 4 cycles (BL8) or 2 cycles (BC4) → REC.
  - REC: wait T_WR (write) or T_RTP (read) → PRE.
  - PRE: drive PRE for 1 cycle → TRP.
  - TRP: wait T_RP-1 cycles → IDLE.
- Write BURST: cycle i drives dq_rise = beat 2i, dq_fall = beat 2i+1, with dqs_oe = 1. dqs_oe is 0 outside BURST.
- Read BURST: sample dq_in_rise into beat 2i and dq_in_fall into beat 2i+1. On the BURST exit edge, load rd_data and pulse rd_valid for 1 cycle.
  - BC4: bits [63:32] = 0.
- Wait counter: 5 bits, loaded on state entry, decremented to 0. A parameter value of 0 or 1 yields a minimum 1-cycle state.
- Ignore req_valid while busy; no queueing.
- reset_n low mid-operation: return to IDLE immediately, NOP driven, dqs_oe 0, no rd_valid, captured beats discarded.
- Latency, write with defaults: transfer edge to first write beat = 1 + T_RCD + CWL cycles; to req_ready high = total of all states.

Optional Feature:
AUTO_PRECHARGE_EN
- Defined: WR/RD are issued with A10_AP = 1. The PRE state is skipped and no PRE command is driven; REC → TRP directly, same total recovery.
- Undefined: A10_AP = 0 on CAS, and an explicit PRE command is issued as above.

Test Plan:
- Reset: hold reset_n low mid-BURST → outputs NOP 11111, dqs_oe 0, req_ready 1 within the same cycle; release → idle, no spurious command.
- BL8 write, bg 1, ba 2, row 0x1A5, col 0x040, data 0x0807060504030201 → ACT 00111 with A13..A0 = 0x1A5; WR 01100 exactly 4 cycles later with A9_A0 = 0x040 and A12_BC_n = 1; dqs_oe high 4 cycles starting 9 cycles after WR; rise/fall pairs 01/02, 03/04, 05/06, 07/08; PRE 12 cycles after last beat.
- BC4 read, dq_in driven 0xA1..0xA4 → RD with A12_BC_n = 0; beats sampled 11 cycles after RD; rd_data = 0x00000000A4A3A2A1 with a single rd_valid pulse.
- Back-to-back: req_valid held high → second transfer only after req_ready returns, exactly T_RP cycles after PRE; no overlapping commands.
- Request while busy: pulse req_valid during LAT → ignored, no extra ACT.
- AUTO_PRECHARGE_EN build, BL8 write → A10_AP = 1 on WR; no PRE command observed; req_ready returns T_WR + T_RP cycles after last beat.

Source files
------------

// File: rtl/ddr_cmd_driver.sv
// rtl/ddr_cmd_driver.sv - DDR4 single-transaction command/data sequencer (ACT, WR/RD, burst, PRE).
// Optional build macro: AUTO_PRECHARGE_EN (WR/RD carry auto-precharge, explicit PRE skipped).
module ddr_cmd_driver #(
  parameter int T_RCD = 4,
  parameter int CWL   = 9,
  parameter int CL    = 11,
  parameter int T_WR  = 12,
  parameter int T_RTP = 6,
  parameter int T_RP  = 4
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [13:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        req_bl4,
  input  logic [63:0] req_wdata,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic [7:0]  dq_rise,
  output logic [7:0]  dq_fall,
  output logic        dqs_oe,
  input  logic [7:0]  dq_in_rise,
  input  logic [7:0]  dq_in_fall,
  output logic [63:0] rd_data,
  output logic        rd_valid
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_ACT   = 4'd1;
  localparam logic [3:0] S_TRCD  = 4'd2;
  localparam logic [3:0] S_CAS   = 4'd3;
  localparam logic [3:0] S_LAT   = 4'd4;
  localparam logic [3:0] S_BURST = 4'd5;
  localparam logic [3:0] S_REC   = 4'd6;
  localparam logic [3:0] S_PRE   = 4'd7;
  localparam logic [3:0] S_TRP   = 4'd8;

`ifdef AUTO_PRECHARGE_EN
  localparam logic AP = 1'b1;
`else
  localparam logic AP = 1'b0;
`endif

  // Counter value for an n-cycle wait; anything below 2 still occupies one cycle.
  function automatic logic [4:0] wait_load(input int n);
    if (n <= 1) return 5'd0;
    else        return 5'(n - 1);
  endfunction

  logic [3:0]  state;
  logic [4:0]  cnt;
  logic [1:0]  beat;
  logic        rw_q;
  logic        bl4_q;
  logic [1:0]  bg_q;
  logic [1:0]  ba_q;
  logic [13:0] row_q;
  logic [9:0]  col_q;
  logic [63:0] wdata_q;
  logic [63:0] rbuf;
  logic [63:0] rbuf_next;
  logic [4:0]  cmd;
  logic [13:0] addr;

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{beat, 4'b0000} +: 8] = dq_in_rise;
    rbuf_next[{beat, 4'b1000} +: 8] = dq_in_fall;
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cnt      <= 5'd0;
      beat     <= 2'd0;
      rw_q     <= 1'b0;
      bl4_q    <= 1'b0;
      bg_q     <= 2'd0;
      ba_q     <= 2'd0;
      row_q    <= 14'd0;
      col_q    <= 10'd0;
      wdata_q  <= 64'd0;
      rbuf     <= 64'd0;
      rd_data  <= 64'd0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: if (req_valid) begin
          rw_q    <= req_rw;
          bl4_q   <= req_bl4;
          bg_q    <= req_bg;
          ba_q    <= req_ba;
          row_q   <= req_row;
          col_q   <= req_col;
          wdata_q <= req_wdata;
          state   <= S_ACT;
        end
        S_ACT: begin
          cnt   <= wait_load(T_RCD - 1);
          state <= S_TRCD;
        end
        S_TRCD: if (cnt == 5'd0) state <= S_CAS; else cnt <= cnt - 5'd1;
        S_CAS: begin
          cnt   <= rw_q ? wait_load(CL - 1) : wait_load(CWL - 1);
          state <= S_LAT;
        end
        S_LAT: if (cnt == 5'd0) begin
          cnt   <= bl4_q ? 5'd1 : 5'd3;
          beat  <= 2'd0;
          rbuf  <= 64'd0;
          state <= S_BURST;
        end else cnt <= cnt - 5'd1;
        S_BURST: begin
          rbuf <= rbuf_next;
          beat <= beat + 2'd1;
          if (cnt == 5'd0) begin
            cnt   <= rw_q ? wait_load(T_RTP) : wait_load(T_WR);
            state <= S_REC;
            if (rw_q) begin
              rd_data  <= bl4_q ? {32'd0, rbuf_next[31:0]} : rbuf_next;
              rd_valid <= 1'b1;
            end
          end else cnt <= cnt - 5'd1;
        end
        S_REC: if (cnt == 5'd0) begin
`ifdef AUTO_PRECHARGE_EN
          // The skipped PRE cycle is folded into tRP so total recovery is unchanged.
          cnt   <= wait_load(T_RP);
          state <= S_TRP;
`else
          state <= S_PRE;
`endif
        end else cnt <= cnt - 5'd1;
        S_PRE: begin
          cnt   <= wait_load(T_RP - 1);
          state <= S_TRP;
        end
        S_TRP: if (cnt == 5'd0) state <= S_IDLE; else cnt <= cnt - 5'd1;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cmd     = 5'b11111;
    addr    = 14'd0;
    bg_addr = 2'd0;
    ba_addr = 2'd0;
    case (state)
      S_ACT: begin
        cmd     = 5'b00111;
        addr    = row_q;
        bg_addr = bg_q;
        ba_addr = ba_q;
      end
      S_CAS: begin
        cmd     = rw_q ? 5'b01101 : 5'b01100;
        addr    = {1'b0, ~bl4_q, 1'b0, AP, col_q};
        bg_addr = bg_q;
        ba_addr = ba_q;
      end
      S_PRE: begin
        cmd     = 5'b01010;
        bg_addr = bg_q;
        ba_addr = ba_q;
      end
      default: ;
    endcase
  end

  assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd;
  assign {A13, A12_BC_n, A11, A10_AP, A9_A0}           = addr;
  assign req_ready = (state == S_IDLE);
  assign dqs_oe    = (state == S_BURST) && !rw_q;
  assign dq_rise   = dqs_oe ? wdata_q[{beat, 4'b0000} +: 8] : 8'd0;
  assign dq_fall   = dqs_oe ? wdata_q[{beat, 4'b1000} +: 8] : 8'd0;

endmodule

// File: tb/tb_ddr_cmd_driver.sv
// tb/tb_ddr_cmd_driver.sv - scoreboard bench for ddr_cmd_driver (default timing parameters).
// Honours AUTO_PRECHARGE_EN when the design is built with it.
module tb_ddr_cmd_driver;

`ifdef AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif

  logic        CK_t, reset_n;
  logic        req_valid, req_ready, req_rw, req_bl4;
  logic [1:0]  req_bg, req_ba;
  logic [13:0] req_row;
  logic [9:0]  req_col;
  logic [63:0] req_wdata;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  bg_addr, ba_addr;
  logic        A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic [7:0]  dq_rise, dq_fall, dq_in_rise, dq_in_fall;
  logic        dqs_oe, rd_valid;
  logic [63:0] rd_data;

  ddr_cmd_driver dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_bl4(req_bl4), .req_wdata(req_wdata),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15),
    .WE_n_A14(WE_n_A14), .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .dq_rise(dq_rise), .dq_fall(dq_fall), .dqs_oe(dqs_oe),
    .dq_in_rise(dq_in_rise), .dq_in_fall(dq_in_fall),
    .rd_data(rd_data), .rd_valid(rd_valid)
  );

  typedef struct { int cyc; logic [4:0] cmd; logic [13:0] addr; logic [1:0] bg; logic [1:0] ba; } cmd_t;
  typedef struct { int cyc; logic [7:0] r; logic [7:0] f; } beat_t;
  typedef struct { int cyc; logic [63:0] d; } rd_t;

  cmd_t  exp_cmd[$];
  beat_t exp_beat[$];
  rd_t   exp_rd[$];
  int    exp_ready[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_ready = 1'b1;

  initial begin
    CK_t = 1'b0;
    forever #5 CK_t = ~CK_t;
  end

  always @(posedge CK_t) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input int c, input logic [4:0] k, input logic [13:0] a,
                          input logic [1:0] g, input logic [1:0] b);
    cmd_t e;
    e.cyc = c; e.cmd = k; e.addr = a; e.bg = g; e.ba = b;
    exp_cmd.push_back(e);
  endtask

  // Expected command/beat/ready timeline for a transaction whose ACT is visible in cycle n.
  task automatic exp_txn(input int n, input bit rd, input logic [1:0] g, input logic [1:0] b,
                         input logic [13:0] row, input logic [9:0] col, input bit bl4,
                         input logic [63:0] wd, input bit full);
    int beats, first, last, rec;
    beat_t bt;
    beats = bl4 ? 2 : 4;
    first = rd ? n + 15 : n + 13;
    last  = first + beats - 1;
    rec   = rd ? 6 : 12;
    push_cmd(n, 5'b00111, row, g, b);
    push_cmd(n + 4, rd ? 5'b01101 : 5'b01100, {1'b0, ~bl4, 1'b0, AP, col}, g, b);
    if (!rd) for (int i = 0; i < (full ? beats : 2); i++) begin
      bt.cyc = first + i; bt.r = wd[16*i +: 8]; bt.f = wd[16*i+8 +: 8];
      exp_beat.push_back(bt);
    end
    if (full) begin
      if (!AP) push_cmd(last + 1 + rec, 5'b01010, 14'd0, g, b);
      exp_ready.push_back(last + 1 + rec + 4);
    end
  endtask

  task automatic set_req(input bit rd, input logic [1:0] g, input logic [1:0] b,
                         input logic [13:0] row, input logic [9:0] col, input bit bl4,
                         input logic [63:0] wd);
    req_rw = rd; req_bg = g; req_ba = b; req_row = row; req_col = col;
    req_bl4 = bl4; req_wdata = wd;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge CK_t);
      if (req_ready) break;
    end
    if (k == 100) chk("wait_idle", 64'(req_ready), 64'd1);
  endtask

  // Scoreboard monitor: checks every presented output against the queued expectations.
  always @(negedge CK_t) begin
    logic [4:0]  k;
    logic [13:0] a;
    cmd_t  e;
    beat_t bt;
    rd_t   r;
    k = {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14};
    a = {A13, A12_BC_n, A11, A10_AP, A9_A0};
    if (k != 5'b11111) begin
      if (exp_cmd.size() == 0) chk("unexpected_cmd", 64'(k), 64'h1f);
      else begin
        e = exp_cmd.pop_front();
        chk("cmd_cycle", 64'(cyc), 64'(e.cyc));
        chk("cmd_code", 64'(k), 64'(e.cmd));
        chk("cmd_addr", 64'(a), 64'(e.addr));
        chk("cmd_bank", 64'({bg_addr, ba_addr}), 64'({e.bg, e.ba}));
      end
    end else chk("nop_addr_zero", 64'({a, bg_addr, ba_addr}), 64'd0);
    if (dqs_oe) begin
      if (exp_beat.size() == 0) chk("unexpected_dqs", 64'(dqs_oe), 64'd0);
      else begin
        bt = exp_beat.pop_front();
        chk("beat_cycle", 64'(cyc), 64'(bt.cyc));
        chk("beat_data", 64'({dq_rise, dq_fall}), 64'({bt.r, bt.f}));
      end
    end
    if (rd_valid) begin
      if (exp_rd.size() == 0) chk("unexpected_rd_valid", 64'(rd_valid), 64'd0);
      else begin
        r = exp_rd.pop_front();
        chk("rd_cycle", 64'(cyc), 64'(r.cyc));
        chk("rd_data", rd_data, r.d);
      end
    end
    if (req_ready && !prev_ready) begin
      if (exp_ready.size() == 0) chk("unexpected_ready", 64'(cyc), 64'd0);
      else chk("ready_cycle", 64'(cyc), 64'(exp_ready.pop_front()));
    end
    prev_ready = req_ready;
  end

  initial begin
    int n, n2;
    rd_t r;
    reset_n = 1'b0; req_valid = 1'b0;
    set_req(1'b0, 2'd0, 2'd0, 14'd0, 10'd0, 1'b0, 64'd0);
    dq_in_rise = 8'd0; dq_in_fall = 8'd0;
    #2;
    chk("reset_cmd", 64'({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}), 64'h1f);
    chk("reset_ready", 64'(req_ready), 64'd1);
    chk("reset_outs", 64'({dqs_oe, rd_valid, dq_rise, dq_fall}), 64'd0);
    chk("reset_rd_data", rd_data, 64'd0);
    repeat (3) @(negedge CK_t);
    reset_n = 1'b1;

    // BL8 write, then a request pulse during LAT that must be ignored.
    wait_idle();
    set_req(1'b0, 2'd1, 2'd2, 14'h1A5, 10'h040, 1'b0, 64'h0807060504030201);
    req_valid = 1'b1; n = cyc + 1;
    exp_txn(n, 1'b0, 2'd1, 2'd2, 14'h1A5, 10'h040, 1'b0, 64'h0807060504030201, 1'b1);
    @(negedge CK_t); req_valid = 1'b0;
    while (cyc != n + 7) @(negedge CK_t);
    set_req(1'b0, 2'd3, 2'd3, 14'h0ABC, 10'h001, 1'b0, 64'd0);
    req_valid = 1'b1;
    @(negedge CK_t); req_valid = 1'b0;

    // BC4 read with beats A1..A4 presented CL cycles after RD.
    wait_idle();
    set_req(1'b1, 2'd2, 2'd3, 14'h3FFF, 10'h3FF, 1'b1, 64'd0);
    req_valid = 1'b1; n = cyc + 1;
    exp_txn(n, 1'b1, 2'd2, 2'd3, 14'h3FFF, 10'h3FF, 1'b1, 64'd0, 1'b1);
    r.cyc = n + 17; r.d = 64'h00000000A4A3A2A1; exp_rd.push_back(r);
    @(negedge CK_t); req_valid = 1'b0;
    while (cyc != n + 15) @(negedge CK_t);
    dq_in_rise = 8'hA1; dq_in_fall = 8'hA2;
    @(negedge CK_t); dq_in_rise = 8'hA3; dq_in_fall = 8'hA4;
    @(negedge CK_t); dq_in_rise = 8'hEE; dq_in_fall = 8'hFF;
    @(negedge CK_t); dq_in_rise = 8'h00; dq_in_fall = 8'h00;

    // Back-to-back: req_valid held, second transfer on the cycle req_ready returns.
    wait_idle();
    set_req(1'b0, 2'd0, 2'd1, 14'h2AAA, 10'h155, 1'b0, 64'h1122334455667788);
    req_valid = 1'b1; n = cyc + 1;
    exp_txn(n, 1'b0, 2'd0, 2'd1, 14'h2AAA, 10'h155, 1'b0, 64'h1122334455667788, 1'b1);
    @(negedge CK_t);
    set_req(1'b0, 2'd3, 2'd0, 14'h0001, 10'h008, 1'b1, 64'h00000000DDCCBBAA);
    n2 = n + 34;
    exp_txn(n2, 1'b0, 2'd3, 2'd0, 14'h0001, 10'h008, 1'b1, 64'h00000000DDCCBBAA, 1'b1);
    while (cyc != n2) @(negedge CK_t);
    req_valid = 1'b0;

    // Reset asserted mid-burst of a BL8 write.
    wait_idle();
    set_req(1'b0, 2'd2, 2'd1, 14'h0123, 10'h2C0, 1'b0, 64'h0807060504030201);
    req_valid = 1'b1; n = cyc + 1;
    exp_txn(n, 1'b0, 2'd2, 2'd1, 14'h0123, 10'h2C0, 1'b0, 64'h0807060504030201, 1'b0);
    exp_ready.push_back(n + 15);
    @(negedge CK_t); req_valid = 1'b0;
    while (cyc != n + 14) @(negedge CK_t);
    @(posedge CK_t); #2 reset_n = 1'b0;
    #1;
    chk("midrst_cmd", 64'({cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}), 64'h1f);
    chk("midrst_dqs_oe", 64'(dqs_oe), 64'd0);
    chk("midrst_ready", 64'(req_ready), 64'd1);
    chk("midrst_rd_valid", 64'(rd_valid), 64'd0);
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
    repeat (6) @(negedge CK_t);

    chk("left_cmd", 64'(exp_cmd.size()), 64'd0);
    chk("left_beat", 64'(exp_beat.size()), 64'd0);
    chk("left_rd", 64'(exp_rd.size()), 64'd0);
    chk("left_ready", 64'(exp_ready.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
